gated_clock_buffer: RTL and testbench

- Glitch-free clock gate: passes the input clock to the output only while an enable is asserted.
- Used wherever a derived or divided clock must be distributed with a clean on/off control, e.g. behind frequency dividers that drive their posedge/negedge clock nets.
- Output pulses are always full-width; an enable change never produces a runt or truncated pulse.

---
 rtl/gated_clock_buffer_pkg.sv | 12 +
 rtl/gated_clock_buffer_sync_chain.sv | 35 +++
 rtl/gated_clock_buffer.sv | 68 ++++++
 tb/tb_gated_clock_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gated_clock_buffer_pkg.sv
// Shared constants and polarity helper for the glitch-free clock gate.
`timescale 1ns/100ps
package gated_clock_buffer_pkg;

  localparam int unsigned MAX_SYNC_STAGES = 4;

  // Conditional inversion used for both the enable and the clock path.
  function automatic logic apply_polarity(input logic i_v, input bit i_inv);
    return i_v ^ logic'(i_inv);
  endfunction

endpackage

// File: rtl/gated_clock_buffer_sync_chain.sv
// Parameterised N-stage synchronizer with an asynchronous reset value.
// With zero stages the input passes straight through.
`timescale 1ns/100ps
module gated_clock_buffer_sync_chain #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_chain
      logic [STAGES-1:0] r_stage;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_stage <= {STAGES{RESET_VAL}};
        end else begin
          r_stage[0] <= i_d;
          for (int unsigned k = 1; k < STAGES; k++) begin
            r_stage[k] <= r_stage[k-1];
          end
        end
      end

      assign o_q = r_stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/gated_clock_buffer.sv
// Glitch-free clock gate: the gate register only changes while the effective
// clock is low, so O carries either full high phases or nothing.
`timescale 1ns/100ps
module gated_clock_buffer
  import gated_clock_buffer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          IS_CE_INVERTED = 1'b0,
  parameter bit          IS_I_INVERTED  = 1'b0,
  parameter bit          RESET_ENABLE   = 1'b0,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 InputCLK,
  input  logic                 Reset,
  input  logic                 CE,
  output logic                 O,
  output logic                 GateOn,
  output logic [CNT_WIDTH-1:0] PulseCount
);

  generate
    if (SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
      $error("SYNC_STAGES out of range");
    end
  endgenerate

  logic                 w_ce_eff;
  logic                 w_clk_eff;
  logic                 w_ce_sync;
  logic                 r_gate;
  logic [CNT_WIDTH-1:0] r_count;

  assign w_ce_eff  = apply_polarity(CE, IS_CE_INVERTED);
  assign w_clk_eff = apply_polarity(InputCLK, IS_I_INVERTED);

  // Enable is resynchronised on the raw input clock's rising edge.
  gated_clock_buffer_sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_ENABLE)
  ) u_sync (
    .i_clk (InputCLK),
    .i_rst (Reset),
    .i_d   (w_ce_eff),
    .o_q   (w_ce_sync)
  );

  // Gate updates only in the low phase of the effective clock.
  always_ff @(negedge w_clk_eff or posedge Reset) begin
    if (Reset) begin
      r_gate <= RESET_ENABLE;
    end else begin
      r_gate <= w_ce_sync;
    end
  end

  always_ff @(posedge w_clk_eff or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (r_gate) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign O          = w_clk_eff & r_gate;
  assign GateOn     = r_gate;
  assign PulseCount = r_count;

endmodule

// File: tb/tb_gated_clock_buffer.sv
// Directed bench for gated_clock_buffer: latency, enable drop, fast CE
// toggling, mid-pulse reset and counter wrap on an inverted-CE instance.
`timescale 1ns/100ps
module tb_gated_clock_buffer;

  logic        clk   = 1'b0;
  logic        rst_a = 1'b0;
  logic        ce_a  = 1'b1;
  logic        o_a;
  logic        gon_a;
  logic [15:0] cnt_a;

  logic        rst_b = 1'b0;
  logic        ce_b  = 1'b0;
  logic        o_b;
  logic        gon_b;
  logic [3:0]  cnt_b;

  int  errors = 0;
  int  checks = 0;
  int  n_rise = 0;
  int  bad_width = 0;
  bit  have_rise = 1'b0;
  real t_rise = 0.0;
  real w;

  gated_clock_buffer #(
    .SYNC_STAGES    (2),
    .IS_CE_INVERTED (1'b0),
    .IS_I_INVERTED  (1'b0),
    .RESET_ENABLE   (1'b0),
    .CNT_WIDTH      (16)
  ) u_dut_a (
    .InputCLK   (clk),
    .Reset      (rst_a),
    .CE         (ce_a),
    .O          (o_a),
    .GateOn     (gon_a),
    .PulseCount (cnt_a)
  );

  gated_clock_buffer #(
    .SYNC_STAGES    (2),
    .IS_CE_INVERTED (1'b1),
    .IS_I_INVERTED  (1'b0),
    .RESET_ENABLE   (1'b0),
    .CNT_WIDTH      (4)
  ) u_dut_b (
    .InputCLK   (clk),
    .Reset      (rst_b),
    .CE         (ce_b),
    .O          (o_b),
    .GateOn     (gon_b),
    .PulseCount (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rising edges of O since reset, and width of every non-reset high phase.
  always @(posedge o_a or posedge rst_a) begin
    if (rst_a) begin
      n_rise    = 0;
      have_rise = 1'b0;
    end else begin
      n_rise++;
      t_rise    = $realtime;
      have_rise = 1'b1;
    end
  end

  always @(negedge o_a) begin
    if (!rst_a && have_rise) begin
      w = $realtime - t_rise;
      if (w < 4.95 || w > 5.05) bad_width++;
    end
  end

  task automatic release_and_first_pulse(input string tag);
    @(negedge clk) rst_a = 1'b0;
    @(posedge clk); #1;
    check({tag, "_gate_e1"}, 32'(gon_a), 32'(0));
    @(posedge clk); #1;
    check({tag, "_gate_e2"}, 32'(gon_a), 32'(0));
    check({tag, "_o_e2"},    32'(o_a),   32'(0));
    @(negedge clk); #1;
    check({tag, "_gate_fall2"}, 32'(gon_a), 32'(1));
    check({tag, "_o_low"},      32'(o_a),   32'(0));
    @(posedge clk); #1;
    check({tag, "_o_e3"},   32'(o_a),   32'(1));
    check({tag, "_cnt_e3"}, 32'(cnt_a), 32'(1));
    #3;
    check({tag, "_o_4ns"}, 32'(o_a), 32'(1));
    #2;
    check({tag, "_o_6ns"}, 32'(o_a), 32'(0));
  endtask

  initial begin
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Held in reset with CE active.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_o",    32'(o_a),   32'(0));
      check("rst_gate", 32'(gon_a), 32'(0));
      check("rst_cnt",  32'(cnt_a), 32'(0));
    end

    release_and_first_pulse("rel1");

    // Edges 4..12 pass, then CE drops between edges.
    repeat (9) @(posedge clk);
    #1;
    check("run_cnt10", 32'(cnt_a), 32'(10));
    #1 ce_a = 1'b0;
    @(posedge clk); #1;
    check("drop_o1",   32'(o_a),   32'(1));
    check("drop_cnt1", 32'(cnt_a), 32'(11));
    @(posedge clk); #1;
    check("drop_o2",   32'(o_a),   32'(1));
    check("drop_cnt2", 32'(cnt_a), 32'(12));
    repeat (4) @(posedge clk);
    #1;
    check("off_o",     32'(o_a),    32'(0));
    check("off_gate",  32'(gon_a),  32'(0));
    check("off_cnt",   32'(cnt_a),  32'(12));
    check("off_rises", 32'(n_rise), 32'(12));

    // CE toggles every 3 ns, offset so it never lands on a clock edge.
    #0.5;
    repeat (67) begin
      #3 ce_a = ~ce_a;
    end
    ce_a = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("tog_cnt",   32'(cnt_a),     32'(n_rise[15:0]));
    check("tog_width", 32'(bad_width), 32'(0));
    check("tog_open",  32'(o_a),       32'(1));

    // Reset while O is high truncates the pulse at once.
    rst_a = 1'b1;
    #0.1;
    check("mid_o",    32'(o_a),   32'(0));
    check("mid_cnt",  32'(cnt_a), 32'(0));
    check("mid_gate", 32'(gon_a), 32'(0));
    #2;
    release_and_first_pulse("rel2");
    check("final_width", 32'(bad_width), 32'(0));

    // Active-low CE held low; 4-bit counter wraps at the 16th pulse.
    @(negedge clk) rst_b = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 2)  check("wrap_n2",  32'(cnt_b), 32'(0));
      if (n == 3)  check("wrap_o3",  32'(o_b),   32'(1));
      if (n == 3)  check("wrap_n3",  32'(cnt_b), 32'(1));
      if (n == 17) check("wrap_n17", 32'(cnt_b), 32'(15));
      if (n == 18) check("wrap_n18", 32'(cnt_b), 32'(0));
      if (n == 20) check("wrap_n20", 32'(cnt_b), 32'(2));
    end
    check("wrap_gate", 32'(gon_b), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
